// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridging a command/response
// handshake onto APB (IDLE -> SETUP -> ACCESS -> RESP).
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout
// that aborts a transfer after TIMEOUT_CYC cycles with pready low.
module apb_master #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    // Without the timeout build TIMEOUT_CYC has no effect; this empty
    // block only keeps the parameter referenced.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // Transfer sequencer: state, APB outputs, and response capture all registered.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        // Reads drive zero data and zero strobes on the bus.
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                        pstrb     <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                end

                ACCESS: begin
                    if (pready) begin
                        state     <= RESP;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // The current wait cycle brings the count to TIMEOUT_CYC: abort.
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= RESP;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        to_cnt    <= to_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a transaction-level
// expectation model checked every cycle, plus literal latency/data checks.
module tb_apb_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    always #5 pclk = ~pclk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs for the current cycle, maintained by the transaction model.
    logic          e_en = 1'b0;
    logic          e_cr, e_psel, e_pen, e_rv, e_pwrite, e_err;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    logic [SW-1:0] e_pstrb;

    always @(negedge pclk) begin
        if (e_en) begin
            cmp("cmd_ready", 32'(cmd_ready), 32'(e_cr));
            cmp("psel",      32'(psel),      32'(e_psel));
            cmp("penable",   32'(penable),   32'(e_pen));
            cmp("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            if (e_psel) begin
                cmp("pwrite", 32'(pwrite), 32'(e_pwrite));
                cmp("paddr",  32'(paddr),  32'(e_paddr));
                cmp("pwdata", pwdata,      e_pwdata);
                cmp("pstrb",  32'(pstrb),  32'(e_pstrb));
            end
            if (e_rv) begin
                cmp("rsp_rdata", rsp_rdata,    e_rdata);
                cmp("rsp_err",   32'(rsp_err), 32'(e_err));
            end
        end
    end

    // Observation of DUT events used by the literal checks.
    logic          m_psel_d = 1'b0, m_pen_d = 1'b0, m_rv_d = 1'b0;
    int            m_psel_cyc = 0, m_pen_cyc = 0, m_rv_cyc = 0, m_addr_cnt = 0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    logic [SW-1:0] m_strb_or = '0;
    logic [AW-1:0] m_addr0 = '0;

    always @(negedge pclk) begin
        if (psel === 1'b1 && m_psel_d !== 1'b1) begin
            m_psel_cyc = cyc;
            m_addr0    = paddr;
            m_addr_cnt = 1;
            m_strb_or  = pstrb;
        end else if (psel === 1'b1) begin
            if (paddr === m_addr0) m_addr_cnt++;
            m_strb_or = m_strb_or | pstrb;
        end
        if (penable === 1'b1 && m_pen_d !== 1'b1) m_pen_cyc = cyc;
        if (rsp_valid === 1'b1 && m_rv_d !== 1'b1) begin
            m_rv_cyc = cyc;
            m_rdata  = rsp_rdata;
            m_err    = rsp_err;
        end
        m_psel_d = psel;
        m_pen_d  = penable;
        m_rv_d   = rsp_valid;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_idle();
        e_en   = 1'b1;
        e_cr   = 1'b1;
        e_psel = 1'b0;
        e_pen  = 1'b0;
        e_rv   = 1'b0;
    endtask

    // One transfer: the APB timeline is laid out from the command parameters
    // (SETUP, waits+1 ACCESS cycles or a timeout, then RESP held 'hold' cycles).
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] st,
                           input int waits, input logic [DW-1:0] rd, input logic er,
                           input int hold, input logic pend, output int acc);
        bit            tmo;
        int            nacc;
        logic [DW-1:0] exp_rd;
        logic          exp_er;
        tmo = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo = (waits >= TO);
`endif
        nacc   = tmo ? TO : waits + 1;
        exp_rd = (tmo || wr) ? '0 : rd;
        exp_er = tmo ? 1'b1 : er;

        set_idle();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wd;   cmd_strb  = st; rsp_ready = 1'b0;
        acc = cyc;
        tick();

        cmd_valid = pend; cmd_write = ~wr; cmd_addr = ~addr;
        cmd_wdata = ~wd;  cmd_strb  = ~st;
        pready = 1'b1; pslverr = ~er; prdata = 32'hBAD0_0001;
        e_cr = 1'b0; e_psel = 1'b1; e_pen = 1'b0; e_rv = 1'b0;
        e_pwrite = wr; e_paddr = addr;
        e_pwdata = wr ? wd : '0;
        e_pstrb  = wr ? st : '0;

        for (int i = 0; i < nacc; i++) begin
            tick();
            e_pen   = 1'b1;
            pready  = (!tmo && i == waits);
            pslverr = (i == waits) ? er : ~er;
            prdata  = (i == waits) ? rd : 32'hBAD0_0100 + 32'(i);
        end

        tick();
        e_pen = 1'b0; e_psel = 1'b0; e_rv = 1'b1;
        e_rdata = exp_rd; e_err = exp_er;
        pready = 1'b1; pslverr = ~exp_er; prdata = 32'hBAD0_0003;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        set_idle();
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int a1, a2, r1;
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
        prdata = 32'hFFFF_FFFF; pready = 1'b1; pslverr = 1'b1;

        // Reset values
        tick(); tick();
        cmp("rst_psel", 32'(psel), 0);
        cmp("rst_penable", 32'(penable), 0);
        cmp("rst_pwrite", 32'(pwrite), 0);
        cmp("rst_paddr", 32'(paddr), 0);
        cmp("rst_pwdata", pwdata, 0);
        cmp("rst_pstrb", 32'(pstrb), 0);
        cmp("rst_rsp_valid", 32'(rsp_valid), 0);
        cmp("rst_rsp_rdata", rsp_rdata, 0);
        cmp("rst_rsp_err", 32'(rsp_err), 0);
        preset = 1'b0; pready = 1'b0; pslverr = 1'b0;
        tick();
        cmp("rst_cmd_ready", 32'(cmd_ready), 1);
        set_idle();
        idle(2);

        // Zero-wait write
        do_xfer(1'b1, 12'h008, 32'h0000_00A5, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0, a1);
        cmp("w_psel_lat", 32'(m_psel_cyc - a1), 1);
        cmp("w_pen_lat", 32'(m_pen_cyc - a1), 2);
        cmp("w_rsp_lat", 32'(m_rv_cyc - a1), 3);
        cmp("w_err", 32'(m_err), 0);
        cmp("w_pstrb", 32'(m_strb_or), 32'hF);
        idle(1);

        // Read with three wait states
        do_xfer(1'b0, 12'h004, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, a1);
        cmp("r_rsp_lat", 32'(m_rv_cyc - a1), 6);
        cmp("r_rdata", m_rdata, 32'hDEAD_BEEF);
        cmp("r_paddr_stable", 32'(m_addr_cnt), 5);
        idle(1);

        // Read with completer error
        do_xfer(1'b0, 12'hFFC, 32'hCAFE_F00D, 4'hF, 0, 32'h1234_5678, 1'b1, 0, 1'b0, a1);
        cmp("e_err", 32'(m_err), 1);
        cmp("e_rdata", m_rdata, 32'h1234_5678);
        cmp("e_pstrb", 32'(m_strb_or), 0);

        // Response back-pressure with a command pending, then the next command
        do_xfer(1'b0, 12'h010, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0, 4, 1'b1, a1);
        r1 = m_rv_cyc;
        do_xfer(1'b1, 12'h020, 32'h0F0F_0F0F, 4'h5, 1, 32'h7777_7777, 1'b1, 0, 1'b0, a2);
        cmp("q_gap", 32'(m_psel_cyc - r1), 6);
        cmp("q_w_rdata", m_rdata, 0);
        cmp("q_w_err", 32'(m_err), 1);
        idle(2);

        // Reset in the middle of ACCESS
        set_idle();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; cmd_strb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        e_cr = 1'b0; e_psel = 1'b1; e_pen = 1'b0; e_rv = 1'b0;
        e_pwrite = 1'b0; e_paddr = 12'h040; e_pwdata = '0; e_pstrb = '0;
        tick();
        e_pen = 1'b1; pready = 1'b0; preset = 1'b1;
        tick();
        e_en = 1'b0;
        cmp("mr_psel", 32'(psel), 0);
        cmp("mr_penable", 32'(penable), 0);
        cmp("mr_rsp_valid", 32'(rsp_valid), 0);
        preset = 1'b0;
        tick();
        cmp("mr_cmd_ready", 32'(cmd_ready), 1);
        set_idle();
        pready = 1'b1;
        idle(4);
        pready = 1'b0;

        // Completer never ready
        do_xfer(1'b0, 12'h100, 32'h0, 4'h0, 100, 32'h0BAD_CAFE, 1'b0, 0, 1'b0, a1);
`ifdef APB_MASTER_TIMEOUT_EN
        cmp("to_rsp_lat", 32'(m_rv_cyc - a1), 32'(2 + TO));
        cmp("to_err", 32'(m_err), 1);
        cmp("to_rdata", m_rdata, 0);
`else
        cmp("nto_rsp_lat", 32'(m_rv_cyc - a1), 103);
        cmp("nto_rdata", m_rdata, 32'h0BAD_CAFE);
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
